pkt_ram_ctrl: RTL and testbench

- Sequencer for the 8x32 dual-port packet RAM that sits behind the PLL clock domain.
- Fills the RAM with one fixed-length packet (write address generated internally), then holds it until downstream requests a drain.
- Drains the packet by stepping the read address across all locations.
- Presents read data with a valid strobe, and flags full and overflow conditions.

---
 rtl/pkt_ram_ctrl_pkg.sv | 16 +
 rtl/pkt_ram_ctrl_addr_cnt.sv | 37 +++
 rtl/pkt_ram_ctrl.sv | 120 ++++++++++++
 tb/tb_pkt_ram_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_ram_ctrl_pkg.sv
// rtl/pkt_ram_ctrl_pkg.sv - shared constants and state encoding for the packet RAM sequencer
package pkt_ram_ctrl_pkg;

    localparam int DW_DEF    = 8;
    localparam int AW_DEF    = 5;
    localparam int DEPTH_DEF = 32;
    localparam int PKT_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_FULL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

endpackage

// File: rtl/pkt_ram_ctrl_addr_cnt.sv
// rtl/pkt_ram_ctrl_addr_cnt.sv - AW-bit address counter with enable, sync clear and terminal-count flag
module pkt_addr_cnt #(
    parameter int             AW   = 5,
    parameter logic [AW-1:0]  LAST = '1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clr,
    output logic [AW-1:0] cnt,
    output logic          tc
);

    logic [AW-1:0] cnt_q;
    logic [AW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == LAST);

endmodule

// File: rtl/pkt_ram_ctrl.sv
// rtl/pkt_ram_ctrl.sv - fill/hold/drain sequencer for the dual-port packet RAM
// Optional packet counter output enabled by PKT_RAM_CTRL_PKT_CNT_EN.
module pkt_ram_ctrl
    import pkt_ram_ctrl_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] data_in,
    input  logic          rd_req,
    output logic          ram_wren,
    output logic [AW-1:0] ram_wraddr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_rden,
    output logic [AW-1:0] ram_rdaddr,
    input  logic [DW-1:0] ram_q,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          package_full,
    output logic          busy,
`ifdef PKT_RAM_CTRL_PKT_CNT_EN
    output logic [PKT_CNT_W-1:0] pkt_cnt,
`endif
    output logic          overflow
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_e state_q;
    state_e state_d;
    logic   overflow_q;
    logic   overflow_d;
    logic   dout_valid_q;
    logic   dout_valid_d;
    logic   wr_tc;
    logic   rd_tc;

    pkt_addr_cnt #(.AW(AW), .LAST(LAST_ADDR)) u_wr_cnt (
        .clk   (clk),
        .rst_n (rst),
        .en    (ram_wren),
        .clr   (state_q == ST_FLUSH),
        .cnt   (ram_wraddr),
        .tc    (wr_tc)
    );

    pkt_addr_cnt #(.AW(AW), .LAST(LAST_ADDR)) u_rd_cnt (
        .clk   (clk),
        .rst_n (rst),
        .en    (ram_rden),
        .clr   (state_q == ST_FILL),
        .cnt   (ram_rdaddr),
        .tc    (rd_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_FILL;
            overflow_q   <= 1'b0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            overflow_q   <= overflow_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL:  if (ram_wren && wr_tc) state_d = ST_FULL;
            ST_FULL:  if (rd_req)            state_d = ST_DRAIN;
            ST_DRAIN: if (rd_tc)             state_d = ST_FLUSH;
            ST_FLUSH:                        state_d = ST_FILL;
            default:                         state_d = ST_FILL;
        endcase
    end

    // Writes outside FILL never reach the RAM, so read and write cannot overlap.
    always_comb begin
        ram_wren     = (state_q == ST_FILL) && wr_en;
        ram_wdata    = ram_wren ? data_in : '0;
        ram_rden     = (state_q == ST_DRAIN);
        package_full = (state_q == ST_FULL);
        busy         = (state_q != ST_FILL);
        overflow_d   = overflow_q | (wr_en && (state_q != ST_FILL));
        dout_valid_d = ram_rden;
    end

    assign overflow   = overflow_q;
    assign dout_valid = dout_valid_q;
    assign dout       = dout_valid_q ? ram_q : '0;

`ifdef PKT_RAM_CTRL_PKT_CNT_EN
    logic [PKT_CNT_W-1:0] pkt_cnt_q;
    logic [PKT_CNT_W-1:0] pkt_cnt_d;

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if ((state_q == ST_FLUSH) && (pkt_cnt_q != '1)) begin
            pkt_cnt_d = pkt_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_pkt_ram_ctrl.sv
// tb/tb_pkt_ram_ctrl.sv - scoreboard bench for pkt_ram_ctrl with a behavioural RAM and packet model
module tb_pkt_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] data_in;
    logic       rd_req;
    logic       ram_wren;
    logic [4:0] ram_wraddr;
    logic [7:0] ram_wdata;
    logic       ram_rden;
    logic [4:0] ram_rdaddr;
    logic [7:0] ram_q = 8'h00;
    logic [7:0] dout;
    logic       dout_valid;
    logic       package_full;
    logic       busy;
    logic       overflow;
`ifdef PKT_RAM_CTRL_PKT_CNT_EN
    logic [15:0] pkt_cnt;
`endif

    always #5 clk = ~clk;

    pkt_ram_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_req       (rd_req),
        .ram_wren     (ram_wren),
        .ram_wraddr   (ram_wraddr),
        .ram_wdata    (ram_wdata),
        .ram_rden     (ram_rden),
        .ram_rdaddr   (ram_rdaddr),
        .ram_q        (ram_q),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .package_full (package_full),
        .busy         (busy),
`ifdef PKT_RAM_CTRL_PKT_CNT_EN
        .pkt_cnt      (pkt_cnt),
`endif
        .overflow     (overflow)
    );

    logic [7:0] mem [32];

    always @(posedge clk) begin
        if (ram_wren) mem[ram_wraddr] <= ram_wdata;
        if (ram_rden) ram_q <= mem[ram_rdaddr];
    end

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];
    int         exp_addr_q[$];
    logic [7:0] fill_words[$];
    bit         model_full = 1'b0;
    bit         model_ovf  = 1'b0;
    int         pkts_done  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (dout_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL dout_extra: got valid word 0x%0h expected none", dout);
                end else begin
                    check("dout", dout, exp_q.pop_front());
                end
            end
            if (ram_rden) begin
                if (exp_addr_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rdaddr_extra: got read at %0d expected none", ram_rdaddr);
                end else begin
                    check("rdaddr", ram_rdaddr, exp_addr_q.pop_front());
                end
            end
            if (ram_wren && (busy || ram_rden)) begin
                tests++;
                fails++;
                $display("FAIL wren_outside_fill: got wren=1 busy=%0d rden=%0d expected wren=0", busy, ram_rden);
            end
        end
    end

    task automatic reset_check(input string tag);
        check({tag, "_wren"}, ram_wren, 0);
        check({tag, "_wraddr"}, ram_wraddr, 0);
        check({tag, "_wdata"}, ram_wdata, 0);
        check({tag, "_rden"}, ram_rden, 0);
        check({tag, "_rdaddr"}, ram_rdaddr, 0);
        check({tag, "_dout"}, dout, 0);
        check({tag, "_valid"}, dout_valid, 0);
        check({tag, "_full"}, package_full, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ovf"}, overflow, 0);
`ifdef PKT_RAM_CTRL_PKT_CNT_EN
        check({tag, "_pkt_cnt"}, pkt_cnt, 0);
`endif
    endtask

    task automatic write_word(input logic [7:0] d, input bit req);
        wr_en   = 1'b1;
        data_in = d;
        rd_req  = req;
        @(negedge clk);
        if (!model_full) begin
            check("wr_pass", ram_wren, 1);
            check("wr_addr", ram_wraddr, fill_words.size());
            check("wr_data", ram_wdata, d);
            if (req) check("rden_in_fill", ram_rden, 0);
            fill_words.push_back(d);
            if (fill_words.size() == 32) model_full = 1'b1;
        end else begin
            check("wr_blocked", ram_wren, 0);
            model_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
        wr_en  = 1'b0;
        rd_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fill_packet(input bit incr, input int req_at);
        for (int i = 0; i < 32; i++) begin
            write_word(incr ? 8'(i) : 8'($urandom), i == req_at);
            if (!incr && i < 31 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        check("full_flag", package_full, 1);
        check("full_busy", busy, 1);
        check("full_rden", ram_rden, 0);
        check("overflow", overflow, model_ovf);
    endtask

    task automatic drain(input bit hold_wr, input int abort_at);
        for (int i = 0; i < fill_words.size(); i++) begin
            exp_q.push_back(fill_words[i]);
            exp_addr_q.push_back(i);
        end
        if (hold_wr) begin
            wr_en     = 1'b1;
            data_in   = 8'($urandom);
            model_ovf = 1'b1;
        end
        rd_req = 1'b1;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        check("drain_rden", ram_rden, 1);
        check("drain_lat", dout_valid, 0);
        if (abort_at >= 0) begin
            idle(abort_at);
            rst = 1'b0;
            #1;
            reset_check("abort");
            exp_q.delete();
            exp_addr_q.delete();
            fill_words.delete();
            model_full = 1'b0;
            model_ovf  = 1'b0;
            pkts_done  = 0;
            @(negedge clk);
            rst = 1'b1;
            @(posedge clk);
            #1;
            return;
        end
        idle(32);
        wr_en = 1'b0;
        check("flush_busy", busy, 1);
        check("flush_rden", ram_rden, 0);
        check("flush_valid", dout_valid, 1);
        idle(1);
        check("back_busy", busy, 0);
        check("back_full", package_full, 0);
        check("back_valid", dout_valid, 0);
        check("exp_left", exp_q.size(), 0);
        check("addr_left", exp_addr_q.size(), 0);
        check("overflow", overflow, model_ovf);
        fill_words.delete();
        model_full = 1'b0;
        pkts_done++;
`ifdef PKT_RAM_CTRL_PKT_CNT_EN
        check("pkt_cnt", pkt_cnt, pkts_done);
`endif
    endtask

    initial begin
        rst     = 1'b0;
        wr_en   = 1'b0;
        rd_req  = 1'b0;
        data_in = 8'hA5;
        idle(2);
        reset_check("rst");
        @(negedge clk);
        rst = 1'b1;
        idle(1);

        fill_packet(1'b1, 10);
        drain(1'b0, -1);

        fill_packet(1'b0, -1);
        for (int i = 0; i < 3; i++) write_word(8'($urandom), 1'b0);
        check("ovf_full", overflow, 1);
        drain(1'b1, -1);

        fill_packet(1'b0, -1);
        drain(1'b0, -1);

        fill_packet(1'b0, -1);
        drain(1'b0, 15);

        fill_packet(1'b0, -1);
        drain(1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
